// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter with a burst cap, sharing one unified memory between the core and the program loader.
// Read data returns one cycle after a granted read; core_stall holds the core while it waits for the bus.
module mem_bus_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0]      core_wdata,
  output logic                  core_gnt,
  output logic [WIDTH-1:0]      core_rdata,
  output logic                  core_valid,
  output logic                  core_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [WIDTH-1:0]      ldr_wdata,
  output logic                  ldr_gnt,
  output logic [WIDTH-1:0]      ldr_rdata,
  output logic                  ldr_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {S_IDLE, S_CORE, S_LDR} state_t;
  typedef enum logic {OWN_CORE, OWN_LDR} owner_t;

  state_t           state, state_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  // Owner-relative view so the CORE and LDR arms share one rule set.
  logic   own_req, oth_req;
  state_t oth_state;
  owner_t own_id;

  always_comb begin
    own_req   = 1'b0;
    oth_req   = 1'b0;
    oth_state = S_IDLE;
    own_id    = OWN_CORE;
    case (state)
      S_CORE: begin
        own_req   = core_req;
        oth_req   = ldr_req;
        oth_state = S_LDR;
        own_id    = OWN_CORE;
      end
      S_LDR: begin
        own_req   = ldr_req;
        oth_req   = core_req;
        oth_state = S_CORE;
        own_id    = OWN_LDR;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    if (state == S_IDLE) begin
      burst_cnt_nxt = '0;
      if (core_req && ldr_req)
        state_nxt = (last_owner == OWN_LDR) ? S_CORE : S_LDR;
      else if (core_req)
        state_nxt = S_CORE;
      else if (ldr_req)
        state_nxt = S_LDR;
    end else if (!own_req) begin
      state_nxt      = oth_req ? oth_state : S_IDLE;
      burst_cnt_nxt  = '0;
      last_owner_nxt = own_id;
    end else if (!oth_req) begin
      burst_cnt_nxt = '0;
    end else if (burst_cnt == CNT_LAST) begin
      state_nxt      = oth_state;
      burst_cnt_nxt  = '0;
      last_owner_nxt = own_id;
    end else begin
      burst_cnt_nxt = burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_owner <= OWN_LDR;
      burst_cnt  <= '0;
      core_valid <= 1'b0;
      ldr_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      core_valid <= core_gnt & core_req & ~core_we;
      ldr_valid  <= ldr_gnt & ldr_req & ~ldr_we;
    end
  end

  assign core_gnt   = (state == S_CORE);
  assign ldr_gnt    = (state == S_LDR);
  assign core_stall = core_req & ~core_gnt;
  assign core_rdata = mem_rdata;
  assign ldr_rdata  = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      S_CORE: begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_req & core_we;
      end
      S_LDR: begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_we    = ldr_req & ldr_we;
      end
      default: ;
    endcase
    if (!rst)
      mem_we = 1'b0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic, checked each cycle against
// a behavioural ownership/memory model and a registered-read memory attached to the DUT.
module tb_mem_bus_arbiter;
  localparam int W  = 32;
  localparam int AW = 6;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we, ldr_req, ldr_we;
  logic [AW-1:0] core_addr, ldr_addr;
  logic [W-1:0]  core_wdata, ldr_wdata;
  logic          core_gnt, core_valid, core_stall, ldr_gnt, ldr_valid, mem_we;
  logic [W-1:0]  core_rdata, ldr_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_valid(core_valid), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_valid(ldr_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached memory: synchronous write, registered read; preload port for initial contents.
  logic [W-1:0]  em [64] = '{default: '0};
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;
  always @(posedge clk) begin
    if (pl_we) em[pl_addr] <= pl_data;
    else if (mem_we) em[mem_addr] <= mem_wdata;
    mem_rdata <= em[mem_addr];
  end

  // Reference model: owner 0=none 1=core 2=loader; m_run = contended accesses served this tenure.
  int          m_owner, m_last, m_run;
  logic        m_cv, m_lv;
  logic [W-1:0] m_rd;
  logic [W-1:0] sh [64];

  logic s_core_gnt, s_ldr_gnt, s_core_valid, s_ldr_valid, s_core_stall, s_mem_we;
  logic [W-1:0] s_core_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    int n_owner, n_last, n_run, other;
    logic mine, theirs, n_cv, n_lv, exp_we;
    logic [W-1:0] n_rd, exp_wd;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    s_core_gnt = core_gnt;   s_ldr_gnt = ldr_gnt;
    s_core_valid = core_valid; s_ldr_valid = ldr_valid;
    s_core_stall = core_stall; s_mem_we = mem_we; s_core_rdata = core_rdata;
    exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
    if (m_owner == 1) begin
      exp_addr = core_addr; exp_wd = core_wdata; exp_we = rst & core_req & core_we;
    end else if (m_owner == 2) begin
      exp_addr = ldr_addr; exp_wd = ldr_wdata; exp_we = rst & ldr_req & ldr_we;
    end
    chk("core_gnt", core_gnt, m_owner == 1);
    chk("ldr_gnt", ldr_gnt, m_owner == 2);
    chk("core_stall", core_stall, core_req && m_owner != 1);
    chk("mem_we", mem_we, exp_we);
    chk("mem_addr", mem_addr, exp_addr);
    if (m_owner != 0) chk("mem_wdata", mem_wdata, exp_wd);
    chk("core_valid", core_valid, m_cv);
    chk("ldr_valid", ldr_valid, m_lv);
    if (m_cv) chk("core_rdata", core_rdata, m_rd);
    if (m_lv) chk("ldr_rdata", ldr_rdata, m_rd);

    n_owner = m_owner; n_last = m_last; n_run = m_run; n_rd = m_rd;
    n_cv = 1'b0; n_lv = 1'b0;
    if (!rst) begin
      n_owner = 0; n_last = 2; n_run = 0;
    end else begin
      n_cv = (m_owner == 1) && core_req && !core_we;
      n_lv = (m_owner == 2) && ldr_req && !ldr_we;
      if (n_cv) n_rd = sh[core_addr];
      if (n_lv) n_rd = sh[ldr_addr];
      if (m_owner == 1 && core_req && core_we) sh[core_addr] = core_wdata;
      if (m_owner == 2 && ldr_req && ldr_we) sh[ldr_addr] = ldr_wdata;
      if (m_owner == 0) begin
        n_run = 0;
        if (core_req && ldr_req) n_owner = (m_last == 1) ? 2 : 1;
        else if (core_req) n_owner = 1;
        else if (ldr_req) n_owner = 2;
      end else begin
        mine   = (m_owner == 1) ? core_req : ldr_req;
        theirs = (m_owner == 1) ? ldr_req : core_req;
        other  = 3 - m_owner;
        if (!mine) begin
          n_owner = theirs ? other : 0; n_run = 0; n_last = m_owner;
        end else if (!theirs) begin
          n_run = 0;
        end else if (m_run + 1 >= MB) begin
          n_owner = other; n_run = 0; n_last = m_owner;
        end else begin
          n_run = m_run + 1;
        end
      end
    end
    @(posedge clk);
    m_owner = n_owner; m_last = n_last; m_run = n_run;
    m_cv = n_cv; m_lv = n_lv; m_rd = n_rd;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; core_req = 1'b0; ldr_req = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  logic cg [40];
  logic lg [40];
  logic cvv [40];
  logic lvv [40];

  initial begin
    logic g, got;
    logic [W-1:0] rd;
    int i;
    rst = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    for (int a = 0; a < 64; a++) sh[a] = '0;
    sh[5] = 32'hDEADBEEF;
    m_owner = 0; m_last = 2; m_run = 0; m_cv = 1'b0; m_lv = 1'b0; m_rd = '0;
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = 6'd5; pl_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    pl_we = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // 1: single core read of addr 5
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd5;
    cycle();
    chk("t1_gnt_c0", s_core_gnt, 1'b0);
    cycle();
    chk("t1_gnt_c1", s_core_gnt, 1'b1);
    chk("t1_ldr_c1", s_ldr_gnt, 1'b0);
    core_req = 1'b0;
    cycle();
    chk("t1_valid_c2", s_core_valid, 1'b1);
    chk("t1_rdata_c2", s_core_rdata, 32'hDEADBEEF);
    chk("t1_ldr_c2", s_ldr_gnt, 1'b0);
    cycle();

    // 2/6: both requesting reads from reset, bursts of MB alternate
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd5;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 6'd7;
    for (int k = 0; k < 26; k++) begin
      cycle();
      cg[k] = s_core_gnt; lg[k] = s_ldr_gnt; cvv[k] = s_core_valid; lvv[k] = s_ldr_valid;
    end
    chk("t2_idle0", cg[0] | lg[0], 1'b0);
    chk("t2_core1", cg[1], 1'b1);
    chk("t2_core8", cg[8], 1'b1);
    chk("t2_ldr9", lg[9], 1'b1);
    chk("t2_core9", cg[9], 1'b0);
    chk("t6_cvalid9", cvv[9], 1'b1);
    chk("t6_lvalid9", lvv[9], 1'b0);
    chk("t2_ldr16", lg[16], 1'b1);
    chk("t2_core17", cg[17], 1'b1);

    // 3: loader fills memory, core reads back addr 63
    core_req = 1'b0;
    ldr_we = 1'b1;
    i = 0;
    for (int k = 0; k < 300 && i < 64; k++) begin
      ldr_addr = AW'(i); ldr_wdata = W'(i + 1);
      g = (m_owner == 2);
      cycle();
      if (g) begin
        chk("t3_we", s_mem_we, 1'b1);
        i++;
      end
    end
    ldr_req = 1'b0; ldr_we = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd63;
    got = 1'b0; rd = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      g = (m_owner == 1);
      cycle();
      if (g) core_req = 1'b0;
      if (s_core_valid) begin got = 1'b1; rd = s_core_rdata; end
    end
    chk("t3_valid63", got, 1'b1);
    chk("t3_rd63", rd, 32'h40);

    // 4: core drops req while loader waits -> direct handoff
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd1;
    for (int k = 0; k < 10 && m_owner != 1; k++) cycle();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 6'd2;
    cycle();
    core_req = 1'b0;
    cycle();
    chk("t4_core_last", s_core_gnt, 1'b1);
    cycle();
    chk("t4_ldr_next", s_ldr_gnt, 1'b1);
    chk("t4_nostall", s_core_stall, 1'b0);
    core_req = 1'b1; core_addr = 6'd3;
    cycle();
    chk("t4_stall", s_core_stall, 1'b1);

    // 5: reset during a loader write burst
    core_req = 1'b0;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 6'd10; ldr_wdata = 32'hA5A50000;
    for (int k = 0; k < 10 && m_owner != 2; k++) cycle();
    for (int k = 0; k < 2; k++) begin
      g = (m_owner == 2);
      cycle();
      if (g) begin ldr_addr = ldr_addr + 6'd1; ldr_wdata = ldr_wdata + 32'd1; end
    end
    rst = 1'b0;
    cycle();
    chk("t5_we_rst", s_mem_we, 1'b0);
    chk("t5_gnt_rst", s_ldr_gnt, 1'b1);
    rst = 1'b1; ldr_req = 1'b0;
    cycle();
    chk("t5_cgnt", s_core_gnt, 1'b0);
    chk("t5_lgnt", s_ldr_gnt, 1'b0);
    chk("t5_cvalid", s_core_valid, 1'b0);
    chk("t5_lvalid", s_ldr_valid, 1'b0);

    // random traffic; a requester holds its request until granted
    for (int k = 0; k < 800; k++) begin
      logic cgn, lgn;
      cgn = (m_owner == 1);
      lgn = (m_owner == 2);
      cycle();
      if (!core_req || cgn) begin
        core_req = ($urandom_range(0, 99) < 60);
        core_we = 1'($urandom_range(0, 1));
        core_addr = AW'($urandom_range(0, 63));
        core_wdata = $urandom;
      end
      if (!ldr_req || lgn) begin
        ldr_req = ($urandom_range(0, 99) < 60);
        ldr_we = 1'($urandom_range(0, 1));
        ldr_addr = AW'($urandom_range(0, 63));
        ldr_wdata = $urandom;
      end
      rst = ($urandom_range(0, 49) != 0);
    end
    rst = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
